// File: rtl/sparc_fetch_unit.sv
// SPARC instruction-fetch initiator: PC/nPC pair with delayed-branch sequencing and an IF/ID latch.
// Optional macro FETCH_ANNUL_EN adds an annul input that squashes the delay slot.
module sparc_fetch_unit #(
  parameter int unsigned          ADDR_WIDTH = 9,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]          NOP_WORD   = 32'h0100_0000
) (
  input  logic                  clk,
  input  logic                  clr,
`ifdef FETCH_ANNUL_EN
  input  logic                  annul,
`endif
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_data,
  input  logic                  stall,
  input  logic                  take_branch,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] npc,
  output logic                  misalign_err
);

  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] npc_q, npc_d;
  logic [31:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  misalign_q, misalign_d;
  logic                  kill_q, kill_d;
  logic                  kill_use;
  logic                  annul_req;

`ifdef FETCH_ANNUL_EN
  assign annul_req = annul;
  assign kill_use  = kill_q;
`else
  assign annul_req = 1'b0;
  assign kill_use  = 1'b0;
`endif

  // Next-state: a stalled edge freezes everything except the misalign pulse.
  always_comb begin
    pc_d          = pc_q;
    npc_d         = npc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = 1'b0;
    kill_d        = kill_q;
    if (!stall) begin
      pc_d          = npc_q;
      npc_d         = take_branch ? {branch_target[ADDR_WIDTH-1:2], 2'b00} : npc_q + WORD_STEP;
      instr_d       = kill_use ? NOP_WORD : mem_data;
      instr_pc_d    = pc_q;
      instr_valid_d = !kill_use;
      misalign_d    = take_branch && (branch_target[1:0] != 2'b00);
      kill_d        = annul_req;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q          <= RESET_PC;
      npc_q         <= RESET_PC + WORD_STEP;
      instr_q       <= NOP_WORD;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      kill_q        <= kill_d;
    end
  end

  assign mem_addr     = pc_q;
  assign pc           = pc_q;
  assign npc          = npc_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = instr_valid_q;
  assign misalign_err = misalign_q;

endmodule

// File: doc/sparc_fetch_unit.md
Name: sparc_fetch_unit

Overview:
- Instruction-fetch initiator for the byte-addressed 512x8 instruction memory, which returns four bytes big-endian as one 32-bit word: {Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]}.
- Holds the SPARC PC/nPC pair and implements delayed-branch sequencing.
- Drives the memory address and registers the fetched word into an IF/ID latch that feeds control_unit.instr.
- Replaces the hand-stepped address counter used in unit benches.

Parameters:
- ADDR_WIDTH, 9, byte-address width of the instruction memory.
- RESET_PC, 0, PC value after reset. Must be a multiple of 4. nPC resets to RESET_PC+4.
- NOP_WORD, 32'h01000000, SPARC nop (sethi 0,%g0) inserted when a slot is killed.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- mem_addr  out  ADDR_WIDTH  byte address to instruction memory. Always equals PC (combinational).
- mem_data  in  32  word returned by memory for mem_addr, valid in the same cycle.
- stall  in  1  hold PC, nPC and the IF/ID latch.
- take_branch  in  1  redirect nPC to branch_target.
- branch_target  in  ADDR_WIDTH  redirect byte address.
- instr  out  32  registered instruction to the decoder.
- instr_pc  out  ADDR_WIDTH  address the current instr was fetched from.
- instr_valid  out  1  instr holds a real fetched word.
- pc  out  ADDR_WIDTH  current PC.
- npc  out  ADDR_WIDTH  current nPC.
- misalign_err  out  1  one-cycle pulse on a misaligned branch_target.

Behaviour:
- Reset (asynchronous, while clr=1), all outputs forced immediately:
  - pc=RESET_PC, npc=RESET_PC+4.
  - instr=NOP_WORD, instr_pc=0, instr_valid=0, misalign_err=0.
- Fetch latency: a word at address A appears on instr one clock edge after mem_addr=A.
- Rising edge with stall=0:
  - instr<=mem_data, instr_pc<=pc, instr_valid<=1.
  - pc<=npc.
  - npc<= take_branch ? {branch_target[ADDR_WIDTH-1:2],2'b00} : npc+4.
- Delayed branch: the word at the old npc (delay slot) is always fetched before the target.
- Rising edge with stall=1:
  - pc, npc, instr, instr_pc and instr_valid hold their values.
  - take_branch is ignored. The requester must hold take_branch/branch_target until a non-stalled edge.
  - misalign_err<=0.
- Arithmetic: npc+4 is modulo 2^ADDR_WIDTH, so 508+4 wraps to 0 with no flag.
- Misalignment: if take_branch=1, stall=0 and branch_target[1:0]!=0:
  - target is truncated to the word boundary;
  - misalign_err=1 for exactly that cycle, otherwise 0.
- Back-to-back take_branch on consecutive edges is legal (branch in delay slot, SPARC DCTI couple). Each edge applies its own target to npc.
- clr asserted mid-operation: state returns to reset values within the same cycle. The first post-reset fetch is from RESET_PC.
- No internal state machine beyond the PC/nPC/latch registers. No deadlock is possible under any stall pattern.

Optional Feature:
- FETCH_ANNUL_EN.
- Defined:
  - Adds input port annul (1 bit).
  - On a non-stalled edge with take_branch=1 and annul=1, a kill flag is set.
  - On the next non-stalled edge, instr<=NOP_WORD and instr_valid<=0, while pc/npc advance normally. This squashes the delay slot (SPARC ",a").
  - Kill flag clears after use and on clr.
  - annul with take_branch=0 also squashes the next slot (untaken annulled branch).
- Undefined: no annul port, no kill flag. Delay slots always execute.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: memory holds words W0..W3 at bytes 0..15; clr high 2 cycles, then low for 4 edges.
  - Response: mem_addr goes 0,4,8,12; instr goes W0,W1,W2,W3; instr_valid rises on the first edge after clr falls.
- Delayed branch:
  - Stimulus: take_branch=1, target=64 on the edge where pc=8.
  - Response: the next fetches are 12 (delay slot), then 64, then 68; instr_pc follows 8,12,64,68.
- Stall:
  - Stimulus: stall=1 for 3 edges with pc=20, take_branch=1 held throughout.
  - Response: pc=20 and instr unchanged throughout; the branch is applied on the first edge after stall drops.
- Wrap/misalign:
  - Stimulus: pc=504 with sequential fetch; then take_branch with target=0x0A6.
  - Response: fetch address sequence 504,508,0; then npc=0x0A4 and misalign_err=1 for exactly one cycle.
- Async reset mid-run:
  - Stimulus: assert clr between edges while pc=40.
  - Response: pc=0, npc=4, instr=32'h01000000, instr_valid=0 before the next edge.
- With FETCH_ANNUL_EN:
  - Stimulus: annulled taken branch at pc=8, target=32.
  - Response: the instr fetched from 12 is NOP_WORD with instr_valid=0; the next instr is the word at 32 with instr_valid=1.
